cv32e40p_hwloop_perm_sequencer: RTL and testbench
=================================================

// Module: cv32e40p_hwloop_perm_sequencer
// PURPOSE
//  Consumer/driver side of the hwloop permuter. Drives the permuter's next_i and random_i ports, and
//  walks its NUM_INPUT-entry permutation vector. Issues loop iteration numbers in permuted order,
//  one group of NUM_INPUT iterations per permutation, over a loop of count_i iterations.
//  Sits between the hwloop controller (iteration consumer) and cv32e40p_hwloop_permuter.
// PARAMETERS
//  NUM_INPUT    4   group size; entries per permutation (only 4 supported)
//  INPUT_WIDTH  2   bits per permutation entry, = $clog2(NUM_INPUT)
//  CTRL_BITS    5   width of random_o; matches the permuter's control width
//  ITER_WIDTH   32  width of iteration count / index
// PORTS
//  clk          in   1                       clock
//  rst_n        in   1                       reset, synchronous, active-low
//  start_i      in   1                       start loop; sampled only in IDLE
//  abort_i      in   1                       abandon loop; return to IDLE next cycle, no done_o
//  count_i      in   ITER_WIDTH              iteration count, sampled with start_i
//  seed_i       in   16                      LFSR seed, sampled with start_i
//  perm_i       in   NUM_INPUT*INPUT_WIDTH   permutation from the permuter (index_o)
//  perm_next_o  out  1                       permuter next_i; one-cycle pulse per group
//  random_o     out  CTRL_BITS               permuter random_i = lfsr[CTRL_BITS-1:0]
//  iter_valid_o out  1                       iter_idx_o is valid
//  iter_ready_i in   1                       consumer accepts; transfer = valid & ready
//  iter_idx_o   out  ITER_WIDTH              iteration number = group_base + perm_i[slot]
//  busy_o       out  1                       state != IDLE
//  done_o       out  1                       one-cycle pulse after the last iteration transfers
// BEHAVIOUR
//  Reset: state=IDLE, group_base=0, slot=0, count=0, lfsr=16'hACE1.
//   All outputs 0 except random_o (lfsr low bits).
//  LFSR: 16-bit Fibonacci; shift left; fb = l[15]^l[13]^l[12]^l[10].
//   Advances exactly in cycles where perm_next_o=1.
//   On start the seed is loaded, with seed_i==0 replaced by 16'hACE1.
//   The first perm_next_o uses random_o derived from the loaded seed.
//  FSM IDLE/ISSUE/DONE.
//  IDLE: start_i & count_i!=0 -> perm_next_o=1 same cycle, load count/seed, group_base=0, slot=0, ->ISSUE.
//   The permuter registers on that edge, so perm_i is valid from the first ISSUE cycle (zero bubble).
//   start_i & count_i==0 -> DONE directly; no perm_next_o.
//  ISSUE: rem = count - group_base (ITER_WIDTH, never underflows).
//   Slot s is live iff rem>=NUM_INPUT or perm_i[s]<rem.
//   Tail skipping is combinational: iter_valid_o and iter_idx_o present the first live slot >= slot,
//    so no bubble cycles occur.
//   iter_valid_o may not drop before its transfer except on abort_i; iter_idx_o holds while stalled.
//   On transfer: if no live slot remains after it in the group:
//    if group_base+NUM_INPUT >= count -> DONE;
//    else group_base += NUM_INPUT, slot=0, perm_next_o=1 in the same cycle (back-to-back groups).
//   Otherwise slot = transferred slot + 1.
//  DONE: done_o=1 for one cycle -> IDLE. start_i in DONE is ignored.
//  abort_i has priority over all else in ISSUE/DONE:
//   -> IDLE next cycle, with iter_valid_o=0, perm_next_o=0 and done_o=0 in the abort cycle.
//  Reset mid-operation wins over everything -> IDLE with reset values.
//  Every iteration in 0..count-1 is issued exactly once; the per-group order is set by perm_i.
//  group_base wraps modulo 2^ITER_WIDTH; count_i near 2^ITER_WIDTH is legal.
// STRUCTURE
//  Shared package cv32e40p_hwloop_pkg:
//   - state enum hwloop_seq_state_e
//   - LFSR_RESET_SEED = 16'hACE1
//   - LFSR tap constants
//   - NUM_INPUT/INPUT_WIDTH defaults, shared with the permuter
//  Sub-module cv32e40p_hwloop_lfsr16 (load, advance, state out).
//  Slot search is an inline priority encoder, not a separate module.
// TESTING (bench instantiates the permuter in USE_BRAM=0 and =1, connected to this block)
//  1. count=8, ready=1 -> 8 transfers in cycles 1..8, no gaps.
//     {0..3} and {4..7} are each issued as a permutation; perm_next_o at cycles 0 and 4; done_o at cycle 9.
//  2. count=6 -> the second group issues only 4 and 5, back-to-back.
//     Slots with perm>=2 are skipped, with no bubbles; 6 transfers total, then done_o.
//  3. count=5, iter_ready_i toggling 1/0 -> iter_idx_o and iter_valid_o stable while stalled.
//     Exactly one transfer per ready cycle; no duplicates or misses.
//  4. count=0 -> no perm_next_o, no iter_valid_o; done_o 1 cycle after start.
//  5. seed=0 -> random_o on the first perm_next_o equals the low 5 bits of 16'hACE1.
//     Repeated runs with the same seed give identical orders.
//  6. abort_i, then rst_n=0 mid-group with count=12 -> IDLE next cycle, no done_o, outputs 0.
//     A subsequent start with count=4 completes normally.

Source files
------------

// File: rtl/cv32e40p_hwloop_pkg.sv
// Shared hwloop definitions: sequencer states, permutation geometry and the 16-bit LFSR
// used to drive the permuter's control input.
package cv32e40p_hwloop_pkg;

    localparam int unsigned HWLOOP_NUM_INPUT   = 4;
    localparam int unsigned HWLOOP_INPUT_WIDTH = 2;

    localparam logic [15:0] LFSR_RESET_SEED = 16'hACE1;
    // Feedback taps at bits 15, 13, 12 and 10
    localparam logic [15:0] LFSR_TAPS       = 16'hB400;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_DONE  = 2'd2
    } hwloop_seq_state_e;

    function automatic logic [15:0] lfsr16_step(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cv32e40p_hwloop_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; value shows the state in effect this cycle,
// so a seed loaded now is visible immediately.
module cv32e40p_hwloop_lfsr16
    import cv32e40p_hwloop_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] state_r;
    logic [15:0] cur_s;
    logic [15:0] next_s;

    // Select the current value (zero seed is remapped) and compute the next state
    always_comb begin
        cur_s  = state_r;
        next_s = state_r;
        if (load) begin
            if (seed == 16'h0000) begin
                cur_s = LFSR_RESET_SEED;
            end else begin
                cur_s = seed;
            end
        end else begin
            cur_s = state_r;
        end
        if (advance) begin
            next_s = lfsr16_step(cur_s);
        end else begin
            next_s = cur_s;
        end
    end

    // LFSR state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= LFSR_RESET_SEED;
        end else begin
            state_r <= next_s;
        end
    end

    assign value = cur_s;

endmodule

// File: rtl/cv32e40p_hwloop_perm_sequencer.sv
// Drives the hwloop permuter and issues loop iterations group by group in the order given
// by its permutation vector, skipping tail slots beyond the loop count without bubbles.
module cv32e40p_hwloop_perm_sequencer
    import cv32e40p_hwloop_pkg::*;
#(
    parameter int unsigned NUM_INPUT   = HWLOOP_NUM_INPUT,
    parameter int unsigned INPUT_WIDTH = HWLOOP_INPUT_WIDTH,
    parameter int unsigned CTRL_BITS   = 5,
    parameter int unsigned ITER_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic [ITER_WIDTH-1:0]            count_i,
    input  logic [15:0]                      seed_i,
    input  logic [NUM_INPUT*INPUT_WIDTH-1:0] perm_i,
    output logic                             perm_next_o,
    output logic [CTRL_BITS-1:0]             random_o,
    output logic                             iter_valid_o,
    input  logic                             iter_ready_i,
    output logic [ITER_WIDTH-1:0]            iter_idx_o,
    output logic                             busy_o,
    output logic                             done_o
);

    hwloop_seq_state_e      state_r, state_n;
    logic [ITER_WIDTH-1:0]  group_base_r, group_base_n;
    logic [ITER_WIDTH-1:0]  count_r, count_n;
    logic [INPUT_WIDTH-1:0] slot_r, slot_n;

    logic [ITER_WIDTH-1:0]  rem_s;
    logic [INPUT_WIDTH-1:0] entry_s [NUM_INPUT];
    logic [NUM_INPUT-1:0]   live_s;
    logic                   found_s;
    logic                   more_s;
    logic [INPUT_WIDTH-1:0] cur_slot_s;
    logic [INPUT_WIDTH-1:0] cur_entry_s;

    logic                   perm_next_s, valid_s, done_s, load_s;
    logic [ITER_WIDTH-1:0]  idx_s;
    logic [15:0]            lfsr_value_s;

    // A slot is live when its iteration lies below the loop count; rem never underflows
    always_comb begin
        rem_s = count_r - group_base_r;
        for (int s = 0; s < NUM_INPUT; s++) begin
            entry_s[s] = perm_i[s*INPUT_WIDTH +: INPUT_WIDTH];
            live_s[s]  = (rem_s >= ITER_WIDTH'(NUM_INPUT)) ||
                         (ITER_WIDTH'(entry_s[s]) < rem_s);
        end
    end

    // Priority encoder: first live slot at or after slot_r, and whether another follows it
    always_comb begin
        found_s    = 1'b0;
        more_s     = 1'b0;
        cur_slot_s = '0;
        for (int s = 0; s < NUM_INPUT; s++) begin
            if (live_s[s] && (INPUT_WIDTH'(s) >= slot_r)) begin
                if (!found_s) begin
                    found_s    = 1'b1;
                    cur_slot_s = INPUT_WIDTH'(s);
                end else begin
                    more_s = 1'b1;
                end
            end else begin
                more_s = more_s;
            end
        end
        cur_entry_s = entry_s[cur_slot_s];
    end

    // Next-state and output logic
    always_comb begin
        state_n      = state_r;
        group_base_n = group_base_r;
        count_n      = count_r;
        slot_n       = slot_r;
        perm_next_s  = 1'b0;
        valid_s      = 1'b0;
        idx_s        = '0;
        done_s       = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (start_i) begin
                    load_s       = 1'b1;
                    count_n      = count_i;
                    group_base_n = '0;
                    slot_n       = '0;
                    if (count_i != '0) begin
                        perm_next_s = 1'b1;
                        state_n     = SEQ_ISSUE;
                    end else begin
                        state_n = SEQ_DONE;
                    end
                end else begin
                    state_n = SEQ_IDLE;
                end
            end
            SEQ_ISSUE: begin
                if (abort_i) begin
                    state_n = SEQ_IDLE;
                end else begin
                    valid_s = found_s;
                    idx_s   = group_base_r + ITER_WIDTH'(cur_entry_s);
                    if (found_s && iter_ready_i) begin
                        if (more_s) begin
                            slot_n = cur_slot_s + INPUT_WIDTH'(1);
                        end else if (rem_s <= ITER_WIDTH'(NUM_INPUT)) begin
                            state_n = SEQ_DONE;
                        end else begin
                            // Back-to-back groups: request the next permutation now
                            group_base_n = group_base_r + ITER_WIDTH'(NUM_INPUT);
                            slot_n       = '0;
                            perm_next_s  = 1'b1;
                        end
                    end else begin
                        slot_n = slot_r;
                    end
                end
            end
            SEQ_DONE: begin
                state_n = SEQ_IDLE;
                if (abort_i) begin
                    done_s = 1'b0;
                end else begin
                    done_s = 1'b1;
                end
            end
            default: begin
                state_n = SEQ_IDLE;
            end
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= SEQ_IDLE;
            group_base_r <= '0;
            count_r      <= '0;
            slot_r       <= '0;
        end else begin
            state_r      <= state_n;
            group_base_r <= group_base_n;
            count_r      <= count_n;
            slot_r       <= slot_n;
        end
    end

    cv32e40p_hwloop_lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .seed    (seed_i),
        .advance (perm_next_s),
        .value   (lfsr_value_s)
    );

    assign perm_next_o  = perm_next_s;
    assign random_o     = lfsr_value_s[CTRL_BITS-1:0];
    assign iter_valid_o = valid_s;
    assign iter_idx_o   = idx_s;
    assign busy_o       = (state_r != SEQ_IDLE);
    assign done_o       = done_s;

endmodule

// File: tb/tb_cv32e40p_hwloop_perm_sequencer.sv
// Bench for the hwloop permutation sequencer, with a behavioural permuter whose permutation
// is a deterministic function of random_o, so equal seeds give equal orders.
module tb_cv32e40p_hwloop_perm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] count = 32'd0;
    logic [15:0] seed = 16'd0;
    logic [7:0]  perm_r;
    logic        perm_next, iter_valid, busy, done;
    logic [4:0]  random;
    logic [31:0] idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cv32e40p_hwloop_perm_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .count_i      (count),
        .seed_i       (seed),
        .perm_i       (perm_r),
        .perm_next_o  (perm_next),
        .random_o     (random),
        .iter_valid_o (iter_valid),
        .iter_ready_i (ready),
        .iter_idx_o   (idx),
        .busy_o       (busy),
        .done_o       (done)
    );

    // Lehmer-code decode of random value modulo 24 into one of the 24 permutations
    function automatic logic [7:0] decode_perm(input logic [4:0] r);
        int k;
        int f;
        int j;
        int pool [4];
        logic [7:0] p;
        k = int'(r) % 24;
        pool = '{0, 1, 2, 3};
        p = 8'h00;
        for (int i = 0; i < 4; i++) begin
            f = (i == 0) ? 6 : (i == 1) ? 2 : 1;
            j = k / f;
            k = k % f;
            p[2*i +: 2] = 2'(pool[j]);
            for (int m = j; m < 3; m++) pool[m] = pool[m+1];
        end
        return p;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] l);
        logic fb;
        fb = l[15] ^ l[13] ^ l[12] ^ l[10];
        return {l[14:0], fb};
    endfunction

    logic [7:0]  perm_q [$];
    logic [31:0] xfer_q [$];
    logic [31:0] exp_q [$];
    int          xfer_cyc [$];
    int          pn_cyc [$];
    logic [4:0]  rnd_q [$];
    int          done_cyc [$];
    int          viol;
    int          valid_cnt;
    logic        ev_valid, ev_pn, ev_done;
    logic        post_busy, post_valid, post_pn, post_done;
    logic [31:0] post_idx;

    always @(posedge clk) begin
        if (!rst_n) begin
            perm_r <= 8'hE4;
        end else if (perm_next) begin
            perm_r <= decode_perm(random);
            perm_q.push_back(decode_perm(random));
        end
    end

    // Every iteration 0..cnt-1 transferred exactly once, nothing else
    function automatic bit covered(input int cnt);
        int hits [64];
        for (int i = 0; i < 64; i++) hits[i] = 0;
        foreach (xfer_q[i]) begin
            if (xfer_q[i] >= 32'(cnt)) return 1'b0;
            hits[xfer_q[i]]++;
        end
        for (int i = 0; i < cnt; i++) if (hits[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    // Expected issue order: each group's permutation filtered to iterations below cnt
    function automatic bit order_ok(input int cnt);
        exp_q.delete();
        foreach (perm_q[g]) begin
            for (int s = 0; s < 4; s++) begin
                if (4 * g + int'(perm_q[g][2*s +: 2]) < cnt)
                    exp_q.push_back(32'(4 * g + int'(perm_q[g][2*s +: 2])));
            end
        end
        if (exp_q.size() != xfer_q.size()) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i] !== xfer_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive_loop(input logic [31:0] cnt, input logic [15:0] sd, input int rmode,
                              input int abort_cyc, input int rst_cyc);
        bit prev_stall;
        bit ev_seen;
        logic [31:0] prev_idx;
        int stop_at;
        perm_q.delete(); xfer_q.delete(); xfer_cyc.delete(); pn_cyc.delete();
        rnd_q.delete(); done_cyc.delete();
        viol = 0; valid_cnt = 0; prev_stall = 1'b0; ev_seen = 1'b0; prev_idx = 32'd0;
        stop_at = 199;
        ev_valid = 1'b0; ev_pn = 1'b0; ev_done = 1'b0;
        post_busy = 1'b1; post_valid = 1'b1; post_pn = 1'b1; post_done = 1'b1; post_idx = 32'hFFFF_FFFF;
        for (int cyc = 0; cyc < 200 && cyc <= stop_at; cyc++) begin
            @(negedge clk);
            start = (cyc == 0);
            count = cnt;
            seed  = sd;
            abort = (cyc == abort_cyc);
            rst_n = (cyc != rst_cyc);
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 2) == 1);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (cyc == abort_cyc || cyc == rst_cyc) begin
                ev_seen = 1'b1;
                ev_valid = iter_valid; ev_pn = perm_next; ev_done = done;
                stop_at = cyc + 2;
            end
            if ((abort_cyc >= 0 && cyc == abort_cyc + 1) || (rst_cyc >= 0 && cyc == rst_cyc + 1)) begin
                post_busy = busy; post_valid = iter_valid; post_pn = perm_next;
                post_done = done; post_idx = idx;
            end
            if (perm_next) begin
                pn_cyc.push_back(cyc);
                rnd_q.push_back(random);
            end
            if (iter_valid) begin
                valid_cnt++;
                if (prev_stall && idx !== prev_idx) viol++;
                if (ready) begin
                    xfer_q.push_back(idx);
                    xfer_cyc.push_back(cyc);
                end
            end else if (prev_stall && !ev_seen) begin
                viol++;
            end
            prev_stall = iter_valid && !ready;
            prev_idx = idx;
            if (done) begin
                done_cyc.push_back(cyc);
                if (stop_at > cyc + 1) stop_at = cyc + 1;
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst_n = 1'b1; ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks += 6;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (iter_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", iter_valid); end
        if (perm_next !== 1'b0) begin failures++; $display("FAIL reset_perm_next: got %0b expected 0", perm_next); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        if (idx !== 32'd0) begin failures++; $display("FAIL reset_idx: got %0d expected 0", idx); end
        if (random !== 5'h01) begin failures++; $display("FAIL reset_random: got %0h expected 01", random); end
    endtask

    task automatic test_full_groups();
        drive_loop(32'd8, 16'($urandom_range(1, 65535)), 0, -1, -1);
        checks++;
        if (xfer_q.size() != 8) begin failures++; $display("FAIL full_xfers: got %0d expected 8", xfer_q.size()); end
        for (int i = 0; i < xfer_cyc.size(); i++) begin
            checks++;
            if (xfer_cyc[i] != i + 1) begin failures++; $display("FAIL full_xfer_cycle: got %0d expected %0d", xfer_cyc[i], i + 1); end
        end
        checks += 4;
        if (!covered(8)) begin failures++; $display("FAIL full_cover: got %0d transfers expected each of 0..7 once", xfer_q.size()); end
        if (!order_ok(8)) begin failures++; $display("FAIL full_order: got %0d items expected %0d in permuted order", xfer_q.size(), exp_q.size()); end
        if (pn_cyc.size() != 2 || pn_cyc[0] != 0 || pn_cyc[1] != 4) begin
            failures++; $display("FAIL full_perm_next: got %0d pulses expected cycles 0 and 4", pn_cyc.size());
        end
        if (done_cyc.size() != 1 || done_cyc[0] != 9) begin
            failures++; $display("FAIL full_done: got %0d pulses expected one at cycle 9", done_cyc.size());
        end
    endtask

    task automatic test_tail_skip();
        drive_loop(32'd6, 16'($urandom_range(1, 65535)), 0, -1, -1);
        checks += 5;
        if (xfer_q.size() != 6) begin failures++; $display("FAIL tail_xfers: got %0d expected 6", xfer_q.size()); end
        if (!covered(6)) begin failures++; $display("FAIL tail_cover: got %0d transfers expected each of 0..5 once", xfer_q.size()); end
        if (!order_ok(6)) begin failures++; $display("FAIL tail_order: got %0d items expected %0d in permuted order", xfer_q.size(), exp_q.size()); end
        if (xfer_cyc.size() != 6 || xfer_cyc[5] != 6) begin failures++; $display("FAIL tail_no_bubble: got %0d transfers expected last at cycle 6", xfer_cyc.size()); end
        if (done_cyc.size() != 1 || done_cyc[0] != 7) begin failures++; $display("FAIL tail_done: got %0d pulses expected one at cycle 7", done_cyc.size()); end
    endtask

    task automatic test_stall();
        drive_loop(32'd5, 16'($urandom_range(1, 65535)), 1, -1, -1);
        checks += 4;
        if (viol != 0) begin failures++; $display("FAIL stall_stable: got %0d violations expected 0", viol); end
        if (!covered(5)) begin failures++; $display("FAIL stall_cover: got %0d transfers expected each of 0..4 once", xfer_q.size()); end
        if (!order_ok(5)) begin failures++; $display("FAIL stall_order: got %0d items expected %0d", xfer_q.size(), exp_q.size()); end
        if (done_cyc.size() != 1 || done_cyc[0] != 10) begin failures++; $display("FAIL stall_done: got %0d pulses expected one at cycle 10", done_cyc.size()); end
        for (int i = 0; i < xfer_cyc.size(); i++) begin
            checks++;
            if (xfer_cyc[i] != 2 * i + 1) begin failures++; $display("FAIL stall_xfer_cycle: got %0d expected %0d", xfer_cyc[i], 2 * i + 1); end
        end
    endtask

    task automatic test_zero_count();
        drive_loop(32'd0, 16'h1234, 0, -1, -1);
        checks += 3;
        if (pn_cyc.size() != 0) begin failures++; $display("FAIL zero_perm_next: got %0d expected 0", pn_cyc.size()); end
        if (valid_cnt != 0) begin failures++; $display("FAIL zero_valid: got %0d expected 0", valid_cnt); end
        if (done_cyc.size() != 1 || done_cyc[0] != 1) begin failures++; $display("FAIL zero_done: got %0d pulses expected one at cycle 1", done_cyc.size()); end
    endtask

    task automatic test_seed();
        logic [15:0] l;
        logic [15:0] sd;
        logic [31:0] first_q [$];
        drive_loop(32'd12, 16'h0000, 0, -1, -1);
        checks += 2;
        if (rnd_q.size() < 1 || rnd_q[0] !== 5'h01) begin failures++; $display("FAIL seed0_random: got %0d pulses expected first random 01", rnd_q.size()); end
        if (pn_cyc.size() != 3) begin failures++; $display("FAIL seed0_groups: got %0d expected 3", pn_cyc.size()); end
        sd = 16'($urandom_range(1, 65535));
        drive_loop(32'd12, sd, 0, -1, -1);
        l = sd;
        foreach (rnd_q[i]) begin
            checks++;
            if (rnd_q[i] !== l[4:0]) begin failures++; $display("FAIL seed_lfsr: got %0h expected %0h", rnd_q[i], l[4:0]); end
            l = ref_step(l);
        end
        first_q = xfer_q;
        drive_loop(32'd12, sd, 2, -1, -1);
        checks++;
        if (first_q.size() != 12 || xfer_q.size() != 12) begin
            failures++; $display("FAIL seed_repeat_size: got %0d and %0d expected 12", first_q.size(), xfer_q.size());
        end else begin
            foreach (first_q[i]) begin
                checks++;
                if (xfer_q[i] !== first_q[i]) begin failures++; $display("FAIL seed_repeat: got %0d expected %0d", xfer_q[i], first_q[i]); end
            end
        end
    endtask

    task automatic test_abort_reset();
        drive_loop(32'd12, 16'h5A5A, 0, 3, -1);
        checks += 8;
        if (ev_valid !== 1'b0) begin failures++; $display("FAIL abort_valid: got %0b expected 0", ev_valid); end
        if (ev_pn !== 1'b0) begin failures++; $display("FAIL abort_perm_next: got %0b expected 0", ev_pn); end
        if (ev_done !== 1'b0) begin failures++; $display("FAIL abort_done: got %0b expected 0", ev_done); end
        if (post_busy !== 1'b0) begin failures++; $display("FAIL abort_post_busy: got %0b expected 0", post_busy); end
        if (post_valid !== 1'b0) begin failures++; $display("FAIL abort_post_valid: got %0b expected 0", post_valid); end
        if (post_pn !== 1'b0) begin failures++; $display("FAIL abort_post_perm_next: got %0b expected 0", post_pn); end
        if (done_cyc.size() != 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", done_cyc.size()); end
        if (xfer_q.size() != 2) begin failures++; $display("FAIL abort_xfers: got %0d expected 2", xfer_q.size()); end
        drive_loop(32'd12, 16'hC3C3, 0, -1, 4);
        checks += 5;
        if (post_busy !== 1'b0) begin failures++; $display("FAIL rst_post_busy: got %0b expected 0", post_busy); end
        if (post_valid !== 1'b0) begin failures++; $display("FAIL rst_post_valid: got %0b expected 0", post_valid); end
        if (post_pn !== 1'b0 || post_done !== 1'b0) begin failures++; $display("FAIL rst_post_pulses: got %0b%0b expected 00", post_pn, post_done); end
        if (post_idx !== 32'd0) begin failures++; $display("FAIL rst_post_idx: got %0d expected 0", post_idx); end
        if (done_cyc.size() != 0) begin failures++; $display("FAIL rst_no_done: got %0d expected 0", done_cyc.size()); end
        drive_loop(32'd4, 16'h0F0F, 0, -1, -1);
        checks += 3;
        if (!covered(4)) begin failures++; $display("FAIL after_rst_cover: got %0d transfers expected 0..3 once", xfer_q.size()); end
        if (!order_ok(4)) begin failures++; $display("FAIL after_rst_order: got %0d items expected %0d", xfer_q.size(), exp_q.size()); end
        if (done_cyc.size() != 1 || done_cyc[0] != 5) begin failures++; $display("FAIL after_rst_done: got %0d pulses expected one at cycle 5", done_cyc.size()); end
    endtask

    task automatic test_random();
        int cnt;
        for (int r = 0; r < 8; r++) begin
            cnt = $urandom_range(1, 23);
            drive_loop(32'(cnt), 16'($urandom), 2, -1, -1);
            checks += 5;
            if (!covered(cnt)) begin failures++; $display("FAIL rand_cover: got %0d transfers expected %0d unique", xfer_q.size(), cnt); end
            if (!order_ok(cnt)) begin failures++; $display("FAIL rand_order: got %0d items expected %0d", xfer_q.size(), exp_q.size()); end
            if (pn_cyc.size() != (cnt + 3) / 4) begin failures++; $display("FAIL rand_groups: got %0d expected %0d", pn_cyc.size(), (cnt + 3) / 4); end
            if (done_cyc.size() != 1) begin failures++; $display("FAIL rand_done: got %0d expected 1", done_cyc.size()); end
            if (viol != 0) begin failures++; $display("FAIL rand_stable: got %0d expected 0", viol); end
        end
    endtask

    initial begin
        test_reset();
        test_full_groups();
        test_tail_skip();
        test_stall();
        test_zero_count();
        test_seed();
        test_abort_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
